// File: rtl/tinybfly.sv
// Iterative grev/gorc unit: one butterfly stage on adjacent bit pairs per cycle,
// then an unzip, so after LOG2 cycles every stage distance is covered in natural order.
module tinybfly #(
  parameter  int XLEN = 32,
  localparam int LOG2 = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op,
  input  logic [XLEN-1:0] rs1,
  input  logic [LOG2-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [LOG2-1:0] LAST = LOG2'(LOG2 - 1);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic [LOG2-1:0]   ctrl_q, ctrl_d;
  logic              op_q, op_d;
  logic [LOG2-1:0]   cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   rd_q, rd_d;

  logic [XLEN-1:0]   bfly, nxt;
  logic              stage_en;
  logic              accept;

  // Adjacent-pair stage; each unzip rotates the index bits so the next stage
  // sees pairs that were twice as far apart in the original word.
  always_comb begin
    stage_en = ctrl_q[cnt_q];
    bfly     = buf_q;
    nxt      = '0;
    for (int i = 0; i < XLEN/2; i++) begin
      if (stage_en) begin
        if (op_q) begin
          bfly[2*i]   = buf_q[2*i] | buf_q[2*i+1];
          bfly[2*i+1] = buf_q[2*i] | buf_q[2*i+1];
        end else begin
          bfly[2*i]   = buf_q[2*i+1];
          bfly[2*i+1] = buf_q[2*i];
        end
      end
    end
    for (int i = 0; i < XLEN/2; i++) begin
      nxt[i]          = bfly[2*i];
      nxt[XLEN/2 + i] = bfly[2*i+1];
    end
  end

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    ctrl_d      = ctrl_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    rd_d        = rd_q;
    case (state_q)
      IDLE: ;
      RUN: begin
        buf_d = nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          rd_d        = nxt;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A retiring DONE can load the next request in the same cycle.
    if (accept) begin
      buf_d   = rs1;
      ctrl_d  = rs2;
      op_d    = op;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      ctrl_q      <= '0;
      op_q        <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      ctrl_q      <= ctrl_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      rd_q        <= rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rd        = rd_q;

endmodule

// File: tb/tb_tinybfly.sv
// Bench for tinybfly at XLEN=32 and XLEN=64: index-arithmetic reference model,
// per-cycle compare process, plus directed literal expectations.
module tb_tinybfly;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid_a [2];
  logic        op_a       [2];
  logic        out_ready_a[2];
  logic [63:0] rs1_a      [2];
  logic [5:0]  rs2_a      [2];
  logic        in_ready_a [2];
  logic        out_valid_a[2];
  logic [31:0] rd32;
  logic [63:0] rd64;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  tinybfly #(.XLEN(32)) u32 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .op(op_a[0]), .rs1(rs1_a[0][31:0]), .rs2(rs2_a[0][4:0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .rd(rd32)
  );

  tinybfly #(.XLEN(64)) u64 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .op(op_a[1]), .rs1(rs1_a[1]), .rs2(rs2_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .rd(rd64)
  );

  function automatic int xl(int n);
    return (n == 0) ? 32 : 64;
  endfunction

  function automatic int lg(int n);
    return (n == 0) ? 5 : 6;
  endfunction

  function automatic logic [63:0] rd_of(int n);
    return (n == 0) ? {32'b0, rd32} : rd64;
  endfunction

  // grev: out[i] = in[i ^ c]; gorc: out[i] = OR of in[j] for every j whose
  // index differs from i only in bits set in c.
  function automatic logic [63:0] ref_perm(logic o, logic [63:0] a, int c, int w);
    logic [63:0] r = '0;
    for (int i = 0; i < w; i++) begin
      if (o) begin
        for (int j = 0; j < w; j++)
          if (((i ^ j) & ~c) == 0) r[i] = r[i] | a[j];
      end else begin
        r[i] = a[i ^ c];
      end
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: 0 idle, 1 running (m_left cycles to go), 2 holding a result.
  int          m_st  [2];
  int          m_left[2];
  logic [63:0] m_res [2];
  logic [63:0] m_rd  [2];

  function automatic logic exp_rdy(int n);
    return (m_st[n] == 0) || (m_st[n] == 2 && out_ready_a[n]);
  endfunction

  always @(posedge clock) begin
    for (int n = 0; n < 2; n++) begin
      if (reset) begin
        m_st[n]   <= 0;
        m_left[n] <= 0;
        m_rd[n]   <= '0;
      end else if (in_valid_a[n] && exp_rdy(n)) begin
        m_st[n]   <= 1;
        m_left[n] <= lg(n);
        m_res[n]  <= ref_perm(op_a[n], rs1_a[n], int'(rs2_a[n]) & (xl(n) - 1), xl(n));
      end else if (m_st[n] == 1) begin
        m_left[n] <= m_left[n] - 1;
        if (m_left[n] == 1) begin
          m_st[n] <= 2;
          m_rd[n] <= m_res[n];
        end
      end else if (m_st[n] == 2 && out_ready_a[n]) begin
        m_st[n] <= 0;
      end
    end
  end

  always @(negedge clock) begin
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("model in_ready[%0d]", n), {63'b0, in_ready_a[n]}, {63'b0, exp_rdy(n)});
      chk($sformatf("model out_valid[%0d]", n), {63'b0, out_valid_a[n]}, {63'b0, m_st[n] == 2});
      if (m_st[n] == 2) chk($sformatf("model rd[%0d]", n), rd_of(n), m_rd[n]);
    end
  end

  // Called at a negedge; returns at the negedge just after the accept edge.
  // Operands are scrambled afterwards so only the sampled copies may matter.
  task automatic issue(int n, logic o, logic [63:0] a, logic [5:0] c);
    in_valid_a[n] = 1'b1;
    op_a[n]       = o;
    rs1_a[n]      = a;
    rs2_a[n]      = c;
    @(posedge clock);
    @(negedge clock);
    in_valid_a[n] = 1'b0;
    op_a[n]       = ~o;
    rs1_a[n]      = {$urandom, $urandom};
    rs2_a[n]      = 6'($urandom);
  endtask

  task automatic wait_done(int n, string nm, logic [63:0] exp);
    int lat = 0;
    while (!out_valid_a[n] && lat <= 20) begin
      @(negedge clock);
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(lg(n)));
    chk({nm, " rd"}, rd_of(n), exp);
  endtask

  task automatic run(int n, logic o, logic [63:0] a, logic [5:0] c, logic [63:0] exp, string nm);
    chk({nm, " model"}, ref_perm(o, a, int'(c) & (xl(n) - 1), xl(n)), exp);
    issue(n, o, a, c);
    wait_done(n, nm, exp);
    @(negedge clock);
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      in_valid_a[n]  = 1'b0;
      op_a[n]        = 1'b0;
      out_ready_a[n] = 1'b1;
      rs1_a[n]       = '0;
      rs2_a[n]       = '0;
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < 2; n++) begin
      chk("reset rd", rd_of(n), 64'h0);
      chk("reset out_valid", {63'b0, out_valid_a[n]}, 64'h0);
      chk("reset in_ready", {63'b0, in_ready_a[n]}, 64'h1);
    end

    run(0, 1'b0, 64'h00000001, 6'd31, 64'h80000000, "grev32 rev");
    run(0, 1'b0, 64'h12345678, 6'd24, 64'h78563412, "grev32 rev8");
    run(0, 1'b0, 64'hDEADBEEF, 6'd0,  64'hDEADBEEF, "grev32 ident");
    run(0, 1'b1, 64'h00010200, 6'd7,  64'h00FFFF00, "gorc32 orcb");
    run(0, 1'b1, 64'h80000000, 6'd31, 64'hFFFFFFFF, "gorc32 all");
    run(0, 1'b1, 64'hA5A50000, 6'd0,  64'hA5A50000, "gorc32 ident");
    run(1, 1'b0, 64'h1, 6'd63, 64'h8000000000000000, "grev64 rev");
    run(1, 1'b1, 64'h0100000000000080, 6'd7, 64'hFF000000000000FF, "gorc64 orcb");
    run(1, 1'b0, 64'h0123456789ABCDEF, 6'd56, 64'hEFCDAB8967452301, "grev64 rev8");

    // Backpressure then back-to-back issue on the retiring cycle.
    out_ready_a[0] = 1'b0;
    issue(0, 1'b0, 64'h00000001, 6'd31);
    wait_done(0, "bp first", 64'h80000000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("bp out_valid", {63'b0, out_valid_a[0]}, 64'h1);
      chk("bp in_ready", {63'b0, in_ready_a[0]}, 64'h0);
      chk("bp rd hold", rd_of(0), 64'h80000000);
    end
    out_ready_a[0] = 1'b1;
    issue(0, 1'b0, 64'h12345678, 6'd24);
    chk("b2b out_valid drop", {63'b0, out_valid_a[0]}, 64'h0);
    chk("b2b in_ready busy", {63'b0, in_ready_a[0]}, 64'h0);
    wait_done(0, "b2b second", 64'h78563412);
    @(negedge clock);

    // Reset while cnt==2.
    issue(0, 1'b0, 64'h12345678, 6'd24);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst mid out_valid", {63'b0, out_valid_a[0]}, 64'h0);
    chk("rst mid rd", rd_of(0), 64'h0);
    chk("rst mid in_ready", {63'b0, in_ready_a[0]}, 64'h1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("rst no stale", {63'b0, out_valid_a[0]}, 64'h0);
    end

    run(0, 1'b1, 64'h00000003, 6'd1, 64'h00000003, "gorc32 after rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tinybfly.md
Name: tinybfly

Overview:
- Iterative generalized bit-permutation unit (grev / gorc) for the bitmanip datapath.
- Applies one butterfly stage per cycle on an XLEN-bit buffer, followed by a perfect unshuffle (unzip). After log2(XLEN) cycles the result is back in natural bit order.
- Parametrised successor to the 32-bit grev-only core. Adds XLEN generalisation, the OR-combine mode (gorc), a synchronous reset, and valid/ready handshakes with result hold under backpressure.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- LOG2, $clog2(XLEN), number of stages and control width; derived, not overridden.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request this cycle.
- op  input  1  0 = grev (swap), 1 = gorc (OR-combine); sampled on accept.
- rs1  input  XLEN  source operand; sampled on accept.
- rs2  input  LOG2  stage control; bit k enables stage k (pair distance 2^k); sampled on accept.
- out_valid  output  1  rd holds a completed result.
- out_ready  input  1  consumer accepts the result.
- rd  output  XLEN  result register; valid only while out_valid=1.

Behaviour:
- Reset, sync active-high, is taken at posedge with reset=1:
  - state=IDLE, buffer=0, ctrl=0, op_q=0, cnt=0, out_valid=0, rd=0.
  - Reset overrides any in-flight operation; the request is discarded and no result is produced.
- States:
  - IDLE: no operation held.
  - RUN: stage counter cnt runs 0..LOG2-1.
  - DONE: result held.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational and 0 during RUN.
- Accept = in_valid & in_ready. On accept:
  - buffer<=rs1, ctrl<=rs2, op_q<=op, cnt<=0, state<=RUN.
- Stage function, for i in 0..XLEN/2-1, with e=ctrl[cnt]:
  - grev: e=1 swaps buffer[2i] and buffer[2i+1]; e=0 passes both through.
  - gorc: e=1 sets both bits to buffer[2i] | buffer[2i+1]; e=0 passes both through.
  - Unzip: next[i] = bfly[2i] and next[XLEN/2+i] = bfly[2i+1].
- RUN, each cycle:
  - buffer<=unzip(bfly(buffer)), cnt<=cnt+1.
  - When cnt==LOG2-1: state<=DONE, out_valid<=1, and rd takes the final unzipped value.
- Latency: accept at edge t, then out_valid=1 after edge t+LOG2 (5 cycles for XLEN=32, 6 for XLEN=64). Latency is fixed and independent of rs2 and op.
- DONE:
  - rd and out_valid hold until out_ready=1 at a posedge.
  - out_ready=1 and no accept: state<=IDLE, out_valid<=0. rd keeps its last value, which is don't-care.
  - out_ready=1 and accept in the same cycle: the result retires and the new request loads, giving back-to-back issue with no bubble. out_valid<=0 at that edge.
- in_valid while busy is ignored; the source must hold the request until in_ready=1.
- rs2=0 is the identity: rd=rs1 after the full LOG2 latency.
- Control is a full LOG2-bit field; there is no masking or wrap beyond that.
- op and rs2 changing after accept have no effect; only the sampled copies are used.

Test Plan:
- XLEN=32, grev, rs1=0x00000001, rs2=31 -> rd=0x80000000. out_valid rises exactly 5 cycles after accept; in_ready=0 for those cycles.
- XLEN=32, grev, rs1=0x12345678, rs2=24 (byte reverse) -> 0x78563412. rs2=0 with rs1=0xDEADBEEF -> 0xDEADBEEF.
- XLEN=32, gorc, rs1=0x00010200, rs2=7 (orc.b) -> 0x00FFFF00. rs1=0x80000000, rs2=31 -> 0xFFFFFFFF.
- Backpressure: hold out_ready=0 for 10 cycles after done. Required: rd stable, out_valid=1 and in_ready=0 throughout. Then pulse out_ready=1 together with in_valid=1 carrying a new request -> the new request is accepted in that same cycle and its result appears 5 cycles later.
- Reset mid-op: assert reset at cnt=2 -> the next cycle shows out_valid=0, rd=0, in_ready=1, and no stale result ever appears.
- XLEN=64, grev, rs1=0x1, rs2=63 -> 0x8000000000000000 with 6-cycle latency. gorc, rs2=7, rs1=0x0100000000000080 -> 0xFF000000000000FF.
